// File: rtl/mem_pkg.sv
// mem_pkg: funct3 load/store encodings and FSM state for the memory access unit
package mem_pkg;
  localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LD = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100, F3_LHU = 3'b101, F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010, F3_SD = 3'b011;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/load_format.sv
// load_format: aligns bus read data to its lane offset and sign/zero-extends it
module load_format
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);
  logic [63:0] sh;
  assign sh = rdata >> {off, 3'b000};
  // pick the extension for the access size; funct3 111 has no load, so it yields 0
  always_comb
    data = funct3 == F3_LB  ? {{56{sh[7]}}, sh[7:0]} :
           funct3 == F3_LH  ? {{48{sh[15]}}, sh[15:0]} :
           funct3 == F3_LW  ? {{32{sh[31]}}, sh[31:0]} :
           funct3 == F3_LD  ? sh :
           funct3 == F3_LBU ? {56'd0, sh[7:0]} :
           funct3 == F3_LHU ? {48'd0, sh[15:0]} :
           funct3 == F3_LWU ? {32'd0, sh[31:0]} : 64'd0;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage bus master (IDLE/BUSY/DONE); MISALIGN_TRAP_EN adds a misalign trap
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_MEM,
  input  logic              mem_write_MEM,
  input  logic [2:0]        funct3_MEM,
  input  logic [ADDR_W-1:0] addr_MEM,
  input  logic [63:0]       wdata_MEM,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wmask,
  input  logic              bus_ack,
  input  logic [63:0]       bus_rdata,
  output logic [63:0]       data_in_MEM,
  output logic              stall
`ifdef MISALIGN_TRAP_EN
  ,output logic             misalign
`endif
);
  state_t state, nxt;
  logic req, bad, go;
  logic [2:0] off, off_q, f3_q;
  logic [7:0] lanes;
  logic [63:0] fmt;
  assign req = mem_read_MEM | mem_write_MEM;
  assign off = addr_MEM[2:0];
`ifdef MISALIGN_TRAP_EN
  assign bad = |(off & (funct3_MEM[1:0] == 2'd0 ? 3'd0 : funct3_MEM[1:0] == 2'd1 ? 3'd1 :
                        funct3_MEM[1:0] == 2'd2 ? 3'd3 : 3'd7));
`else
  assign bad = 1'b0;
`endif
  assign go = state == IDLE && req && !bad;
  assign lanes = funct3_MEM[1:0] == 2'd0 ? 8'h01 : funct3_MEM[1:0] == 2'd1 ? 8'h03 :
                 funct3_MEM[1:0] == 2'd2 ? 8'h0F : 8'hFF;
  load_format u_fmt (.rdata(bus_rdata), .off(off_q), .funct3(f3_q), .data(fmt));
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  // DONE always returns to IDLE so the pipeline advances exactly once per access
  always_comb
    nxt = state == IDLE ? (go ? BUSY : IDLE) :
          state == BUSY ? (bus_ack ? DONE : BUSY) : IDLE;
  // latch the bus request on entry to BUSY; capture formatted load data on ack
  always_ff @(posedge clk)
    if (rst) begin
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_wmask <= '0;
      off_q <= '0;
      f3_q <= '0;
      data_in_MEM <= '0;
    end else begin
      if (go) begin
        bus_we <= mem_write_MEM;
        bus_addr <= {addr_MEM[ADDR_W-1:3], 3'b000};
        bus_wdata <= wdata_MEM << {off, 3'b000};
        bus_wmask <= funct3_MEM[1:0] == 2'd3 ? 8'hFF : lanes << off;
        off_q <= off;
        f3_q <= funct3_MEM;
      end
      if (state == BUSY && bus_ack && !bus_we) data_in_MEM <= fmt;
    end
  // request while BUSY; stall from the first IDLE cycle of an access until DONE
  always_comb begin
    bus_req = state == BUSY;
    stall = go || state == BUSY;
`ifdef MISALIGN_TRAP_EN
    misalign = state == IDLE && req && bad;
`endif
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  import mem_pkg::*;
  logic clk = 0, rst = 1, mem_read_MEM = 0, mem_write_MEM = 0, bus_ack = 0;
  logic [2:0] funct3_MEM = 0;
  logic [63:0] addr_MEM = 0, wdata_MEM = 0, bus_rdata = 0;
  logic bus_req, bus_we, stall;
  logic [63:0] bus_addr, bus_wdata, data_in_MEM;
  logic [7:0] bus_wmask;
`ifdef MISALIGN_TRAP_EN
  logic misalign;
`endif
  int n_tests = 0, n_fail = 0;
  logic [63:0] last_ld = 0;
  typedef struct {logic we; logic [63:0] addr, wdata, data; logic [7:0] wmask; int stalls;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  mem_access_unit dut (
    .clk(clk), .rst(rst), .mem_read_MEM(mem_read_MEM), .mem_write_MEM(mem_write_MEM),
    .funct3_MEM(funct3_MEM), .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .data_in_MEM(data_in_MEM), .stall(stall)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ld_model(input logic [2:0] f3, input logic [2:0] o, input logic [63:0] rd);
    logic [63:0] r = 0;
    int n = 1 << f3[1:0];
    if (f3 == 3'b111) return 64'd0;
    for (int i = 0; i < n; i++) if (int'(o) + i < 8) r[8*i+:8] = rd[8*(int'(o)+i)+:8];
    if (!f3[2] && n < 8 && r[8*n-1]) for (int i = n; i < 8; i++) r[8*i+:8] = 8'hFF;
    return r;
  endfunction
  task automatic push(input logic wr, input logic [2:0] f3, input logic [63:0] a, wd, rdat, input int w);
    exp_t e;
    logic [2:0] o = a[2:0];
    int n = 1 << f3[1:0];
    e.we = wr;
    e.addr = a & ~64'h7;
    e.stalls = w + 2;
    e.wdata = 0;
    e.wmask = 0;
    for (int i = 0; i < 8; i++)
      if (int'(o) + i < 8) begin
        e.wdata[8*(int'(o)+i)+:8] = wd[8*i+:8];
        if (i < n) e.wmask[int'(o)+i] = 1'b1;
      end
    if (n == 8) e.wmask = 8'hFF;
    e.data = ld_model(f3, o, rdat);
    sb.push_back(e);
  endtask
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] a, wd, rdat, input int w);
    exp_t e;
    int stalls = 0, busy = 0;
    bit done = 0;
    push(wr, f3, a, wd, rdat, w);
    mem_read_MEM = rd; mem_write_MEM = wr; funct3_MEM = f3; addr_MEM = a; wdata_MEM = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      #2;
      if (stall) stalls++;
      if (bus_req) begin
        e = sb[0];
        chk("bus_we", bus_we, e.we);
        chk("bus_addr", bus_addr, e.addr);
        if (e.we) begin
          chk("bus_wmask", bus_wmask, e.wmask);
          chk("bus_wdata", bus_wdata, e.wdata);
        end
        bus_ack = busy == w;
        bus_rdata = busy == w ? rdat : {$urandom, $urandom};
        busy++;
      end else if (busy > 0) begin
        e = sb.pop_front();
        bus_ack = 0;
        if (!e.we) begin
          chk("load_data", data_in_MEM, e.data);
          last_ld = e.data;
        end
        chk("stall_cycles", stalls, e.stalls);
        mem_read_MEM = 0; mem_write_MEM = 0;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      chk("timeout", 0, 1);
      void'(sb.pop_front());
      bus_ack = 0; mem_read_MEM = 0; mem_write_MEM = 0;
      rst = 1; @(posedge clk); #1; rst = 0;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wmask", bus_wmask, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_data", data_in_MEM, 0);
    rst = 0;
    bus_ack = 1;
    @(posedge clk); #1;
    chk("ack_idle_ignored", bus_req, 0);
    bus_ack = 0;
    txn(1, 0, F3_LB, 64'h1003, 0, 64'h0000_0000_8000_0000, 0);
    txn(0, 1, F3_SH, 64'h2006, 64'hBEEF, 0, 1);
    txn(1, 0, F3_LWU, 64'h10, 0, 64'hFFFF_FFFF, 3);
    txn(1, 1, F3_SW, 64'h3004, 64'h1234_5678, 0, 0);
    txn(1, 0, F3_LD, 64'h4000, 0, 64'h8123_4567_89AB_CDEF, 2);
    txn(1, 0, 3'b111, 64'h4008, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    txn(1, 0, F3_LH, 64'h500A, 0, 64'h0000_8001_0000_0000, 1);
    txn(0, 1, F3_SD, 64'h6008, 64'h0102_0304_0506_0708, 0, 0);
`ifndef MISALIGN_TRAP_EN
    txn(1, 0, F3_LW, 64'h1006, 0, 64'hABCD_0000_0000_0000, 0);
    txn(0, 1, F3_SW, 64'h2007, 64'hAABB_CCDD, 0, 1);
`endif
    for (int k = 0; k < 12; k++) begin
      logic wr = 1'($urandom_range(0, 1));
      logic [2:0] f3 = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      logic [2:0] o = 3'($urandom_range(0, 7)) & ~3'((1 << f3[1:0]) - 1);
      logic [63:0] a = {32'd0, $urandom} & ~64'h7 | {61'd0, o};
      txn(!wr, wr, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end
`ifdef MISALIGN_TRAP_EN
    mem_read_MEM = 1; funct3_MEM = F3_LW; addr_MEM = 64'h102;
    #2;
    chk("misalign_flag", misalign, 1);
    chk("misalign_stall", stall, 0);
    chk("misalign_req", bus_req, 0);
    @(posedge clk); #1;
    mem_read_MEM = 0;
    #2;
    chk("misalign_no_req", bus_req, 0);
    chk("misalign_clear", misalign, 0);
    chk("misalign_data", data_in_MEM, last_ld);
    @(posedge clk); #1;
`endif
    mem_read_MEM = 1; funct3_MEM = F3_LW; addr_MEM = 64'h40;
    @(posedge clk); #1;
    chk("pre_rst_busy", bus_req, 1);
    rst = 1; mem_read_MEM = 0;
    @(posedge clk); #1;
    rst = 0; bus_ack = 1; bus_rdata = 64'h7777_7777_7777_7777;
    chk("rst_busy_req", bus_req, 0);
    chk("rst_busy_data", data_in_MEM, 0);
    @(posedge clk); #1;
    bus_ack = 0;
    chk("rst_ack_ignored_req", bus_req, 0);
    chk("rst_ack_ignored_stall", stall, 0);
    chk("rst_ack_ignored_data", data_in_MEM, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
